ex_mult_unit: RTL and testbench

//  Iterative 32x32->64 multiplier in the EX stage; its product feeds the EX/MEM register's 64-bit prod field.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/mult_shift_add_step.sv | 22 ++
 rtl/ex_mult_unit.sv | 115 +++++++++++
 tb/tb_ex_mult_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the EX-stage multiplier.
package pipe_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper half of the accumulator (keeping the carry), then shift right by one.
module mult_shift_add_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mbit,
    output logic [2*WIDTH-1:0] acc_out
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH:0] sum;

    // Add into the upper half; the carry becomes the new MSB after the shift.
    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (mbit ? {1'b0, mcand} : '0);
        acc_out = PW'({sum, acc_in[WIDTH-1:0]} >> 1);
    end

endmodule

// File: rtl/ex_mult_unit.sv
// EX-stage iterative 32x32->64 multiplier: fixed-latency shift-add core with
// signed/unsigned operands, flush support and a stall request to the hazard unit.
module ex_mult_unit
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic               flush,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               busy,
    output logic               done,
    output logic               stall_req,
    output logic [2*WIDTH-1:0] prod
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_t        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Operand magnitudes; 0x8000_0000 negates to itself, which is 2^31 unsigned.
    always_comb begin
        mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    mult_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in  (acc_q),
        .mcand   (mcand_q),
        .mbit    (mplier_q[0]),
        .acc_out (acc_step)
    );

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        // Squashed op: prod keeps the last completed result.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= acc_step;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            prod_q  <= neg_q ? -acc_step : acc_step;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Hold the front of the pipe while a multiply is being accepted or running.
    always_comb begin
        stall_req = (start && (state_q == IDLE)) || (state_q == RUN);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: tb/tb_ex_mult_unit.sv
// Scoreboard bench for ex_mult_unit: the driver pushes expected products and
// done cycles, an independent monitor pops and compares on every done pulse.
module tb_ex_mult_unit;

    localparam int unsigned W = 32;

    typedef struct {
        logic [63:0] prod;
        int unsigned cyc;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic          is_signed;
    logic          flush;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          busy;
    logic          done;
    logic          stall_req;
    logic [2*W-1:0] prod;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_cmp;
    int          n_bad;

    ex_mult_unit #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .prod      (prod)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge index: value after edge k is k.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (done) begin
            check("busy_with_done", {63'd0, busy}, 64'd0);
            check("stall_in_done", {63'd0, stall_req}, 64'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got prod %h expected no done", prod);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("prod", prod, e.prod);
                check("done_cycle", 64'(cyc + 1), 64'(e.cyc));
            end
        end
    end

    // Issue one op from IDLE; done is expected in the cycle ending at edge accept+W+1.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [63:0] exp);
        exp_t e;
        @(posedge clock);
        #1;
        start = 1'b1; src_a = a; src_b = b; is_signed = s;
        e.prod = exp;
        e.cyc  = cyc + 1 + W + 1;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        check("stall_in_run", {63'd0, stall_req}, 64'd1);
        repeat (W + 2) @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t e;
        int   bad_cyc;
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
        src_a = '0; src_b = '0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_prod", prod, 64'd0);
        check("reset_stall", {63'd0, stall_req}, 64'd0);
        reset = 1'b1;

        // Unsigned, signed and boundary operands.
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        do_mul(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        do_mul(32'd0, 32'h1234_5678, 1'b0, 64'd0);
        do_mul(32'd1, 32'h8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000);
        check("prod_stable_after_done", prod, 64'hFFFF_FFFF_8000_0000);

        // Flush at RUN cycle 10: no done, prod keeps 42.
        do_mul(32'd6, 32'd7, 1'b0, 64'd42);
        @(posedge clock);
        #1;
        start = 1'b1; src_a = 32'd5; src_b = 32'd6; is_signed = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_stall", {63'd0, stall_req}, 64'd0);
        check("flush_prod", prod, 64'd42);
        repeat (W + 4) @(posedge clock);
        #1;
        check("flush_prod_later", prod, 64'd42);
        do_mul(32'd2, 32'd3, 1'b0, 64'd6);

        // Flush together with start in IDLE: start ignored.
        start = 1'b1; flush = 1'b1; src_a = 32'd9; src_b = 32'd9;
        @(posedge clock);
        #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {63'd0, busy}, 64'd0);
        repeat (W + 4) @(posedge clock);
        #1;

        // A start pulse in mid-RUN with other operands is ignored.
        start = 1'b1; src_a = 32'd11; src_b = 32'd13; is_signed = 1'b0;
        e.prod = 64'd143;
        e.cyc  = cyc + 1 + W + 1;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1; src_a = 32'd100; src_b = 32'd100;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (W + 3) @(posedge clock);
        #1;

        // Async reset mid-RUN, asserted between edges.
        start = 1'b1; src_a = 32'd9; src_b = 32'd9;
        e.prod = 64'd81;
        e.cyc  = cyc + 1 + W + 1;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        void'(sb.pop_back());
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_prod", prod, 64'd0);
        check("arst_stall", {63'd0, stall_req}, 64'd0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        repeat (W + 4) @(posedge clock);
        #1;
        do_mul(32'd7, 32'd8, 1'b0, 64'd56);

        // start held high: three results spaced W+2 edges apart.
        start = 1'b1; src_a = 32'd3; src_b = 32'd5; is_signed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e.prod = 64'd15;
            e.cyc  = cyc + 1 + k * (W + 2) + W + 1;
            sb.push_back(e);
        end
        bad_cyc = 0;
        repeat (3 * (W + 2)) begin
            @(negedge clock);
            if (stall_req !== ~done) bad_cyc++;
            @(posedge clock);
        end
        #1;
        start = 1'b0;
        check("stall_low_only_in_done", 64'(bad_cyc), 64'd0);
        repeat (W + 4) @(posedge clock);
        #1;

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
